rle_encoder: RTL and testbench
==============================

RLE_ENCODER -- requirements
Module: rle_encoder

Interface
REQ-001 SHALL have parameter FIELD_W, default 16: maximum width of one input field.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on posedge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port field_valid, input, 1 bit: field_data/field_len hold a field to encode.
REQ-005 SHALL have port field_data, input, FIELD_W bits: field value, right-justified, sent MSB first.
REQ-006 SHALL have port field_len, input, 5 bits: field width, 1..FIELD_W; 0 means field ignored.
REQ-007 SHALL have port field_ready, output, 1 bit: field accepted when field_valid && field_ready on a posedge.
REQ-008 SHALL have port flush, input, 1 bit: end of stream; sampled only when field_ready=1.
REQ-009 SHALL have port data, output, 32 bits: packed run-length word to the IO decoder.
REQ-010 SHALL have port interrupt, output, 1 bit: data holds a valid word, or end-of-load strobe.
REQ-011 SHALL have port load_process, output, 1 bit: 1 during the load phase.
REQ-012 SHALL have port done_cpu, input, 1 bit: one-cycle pulse from decoder meaning the word was consumed.
REQ-013 SHALL have port word_count, output, 16 bits: number of words consumed since reset.

Function
REQ-014 Nibble format SHALL be {bit, len[2:0]}, with len 1..7; len=0 SHALL mean pad. Nibble 0 SHALL occupy data[31:28] and nibble 7 SHALL occupy data[3:0].
REQ-015 Field bits SHALL be serialised MSB first, one bit per clock; a field of L bits SHALL occupy L cycles in SHIFT.
REQ-016 Each bit SHALL update the run register as follows:
  - empty run: start the run with len=1;
  - same bit and len<7: increment len;
  - otherwise: close the run into nibble k, increment k, and start a new run (len=1).
REQ-017 When k reaches 8 the block SHALL go to EMIT. The open run SHALL be retained, and shifting SHALL pause with the bit position kept.
REQ-018 FSM states SHALL be IDLE, SHIFT, EMIT, FLUSH, END.
  - IDLE -> SHIFT on an accepted field.
  - IDLE -> FLUSH on flush.
  - SHIFT -> IDLE after the last bit.
  - SHIFT -> EMIT when the word is full.
  - EMIT -> SHIFT or IDLE on done_cpu.
  - FLUSH -> EMIT if any nibble or run is open, else FLUSH -> END.
  - END -> IDLE after one cycle.
REQ-019 field_ready SHALL be 1 only in IDLE. flush SHALL take priority over field_valid in the same cycle.
REQ-020 In EMIT:
  - interrupt=1 and data SHALL be held stable until done_cpu is sampled high;
  - the next cycle SHALL clear interrupt, k and the nibble buffer;
  - interrupt SHALL stay low for at least 1 cycle between words.
REQ-021 done_cpu outside EMIT SHALL be ignored.
REQ-022 FLUSH SHALL close the open run, pad the remaining nibbles with 4'h0, and emit the word. A flush-originated EMIT SHALL then go to END.
REQ-023 load_process SHALL be 1 from reset release until entry to END. In END: interrupt=1 and load_process=0 for exactly 1 cycle (the coordinator start strobe). After END, load_process SHALL stay 0 until reset.
REQ-024 field_len > FIELD_W SHALL be clamped to FIELD_W.

Reset
REQ-025 While rst=0, all registers SHALL clear immediately: state=IDLE, k=0, run empty, data=0, interrupt=0, word_count=0.
REQ-026 After reset release: load_process=1 and field_ready=1 from the first posedge.
REQ-027 Reset asserted mid-field or mid-EMIT SHALL discard all partial data; no word SHALL be emitted for it.

Configuration
REQ-028 Macro RLE_WORD_COUNT_EN SHALL control the word counter.
  - Defined: word_count SHALL increment by 1 on each done_cpu accepted in EMIT, wrapping from 16'hFFFF to 0.
  - Undefined: word_count SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-029 Field 6'b000101 (len 6), then flush -> one word data=32'h39190000; then END strobe with interrupt=1 and load_process=0 for 1 cycle.
REQ-030 Field 16'hFFFF (len 16), then flush -> data=32'hFFA00000 (runs of 7, 7, 2).
REQ-031 Fill 8 nibbles with alternating bits and withhold done_cpu for 10 cycles -> data and interrupt stable, field_ready=0. Then pulse done_cpu -> interrupt=0 next cycle, and the remaining bits resume from the saved position.
REQ-032 Flush with no open run -> no EMIT; FLUSH->END directly; interrupt=1 and load_process=0 for exactly 1 cycle.
REQ-033 Drive rst low during SHIFT of the 9th bit of a 16-bit field -> outputs reset asynchronously. The next field after release encodes as if first; no stale nibbles appear.
REQ-034 With RLE_WORD_COUNT_EN defined, consume 3 words -> word_count=3. Without the macro -> word_count=0 throughout.

Source files
------------

// File: rtl/rle_encoder.sv
// rtl/rle_encoder.sv - run-length encoder packing field bits into 8-nibble words (optional counter: RLE_WORD_COUNT_EN)
module rle_encoder #(
  parameter int FIELD_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               field_valid,
  input  logic [FIELD_W-1:0] field_data,
  input  logic [4:0]         field_len,
  output logic               field_ready,
  input  logic               flush,
  output logic [31:0]        data,
  output logic               interrupt,
  output logic               load_process,
  input  logic               done_cpu,
  output logic [15:0]        word_count
);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_EMIT, S_FLUSH, S_END} state_t;

  localparam logic [4:0] MAX_LEN = 5'(FIELD_W);

  state_t             state, state_next;
  logic [FIELD_W-1:0] field_sr;     // field left-justified, current bit at MSB
  logic [4:0]         bits_left;    // bits of the current field still to shift
  logic [3:0]         k;            // closed nibbles in the word, 0..8
  logic [31:0]        nib_buf;
  logic               run_bit;
  logic [2:0]         run_len;      // 0 means no open run
  logic               from_flush;   // the pending EMIT was started by FLUSH
  logic               ended;        // END has been visited since reset
  logic               load_q;

  logic [4:0]         eff_len;
  logic               cur_bit;
  logic               close_run;
  logic               word_full;
  logic               has_open;
  logic [3:0]         closed_nib;
  logic [31:0]        buf_ins;

  // Run bookkeeping shared by SHIFT and FLUSH
  always_comb begin
    eff_len    = (field_len > MAX_LEN) ? MAX_LEN : field_len;
    cur_bit    = field_sr[FIELD_W-1];
    close_run  = (run_len != 3'd0) && ((cur_bit != run_bit) || (run_len == 3'd7));
    word_full  = close_run && (k == 4'd7);
    has_open   = (k != 4'd0) || (run_len != 3'd0);
    closed_nib = {run_bit, run_len};
    buf_ins    = nib_buf;
    for (int i = 0; i < 8; i++) begin
      if (k == 4'(i)) buf_ins[28-4*i +: 4] = closed_nib;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic; flush wins over a simultaneous field
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (flush)                                  state_next = S_FLUSH;
        else if (field_valid && eff_len != 5'd0)    state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (word_full)                              state_next = S_EMIT;
        else if (bits_left == 5'd1)                 state_next = S_IDLE;
      end
      S_EMIT: begin
        if (done_cpu) begin
          if (from_flush)                           state_next = S_END;
          else if (bits_left != 5'd0)               state_next = S_SHIFT;
          else                                      state_next = S_IDLE;
        end
      end
      S_FLUSH:  state_next = has_open ? S_EMIT : S_END;
      S_END:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; END doubles as the coordinator start strobe
  always_comb begin
    field_ready  = (state == S_IDLE);
    interrupt    = (state == S_EMIT) || (state == S_END);
    load_process = load_q;
  end

  // Datapath: field shifter, run register, nibble buffer and output word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      field_sr   <= '0;
      bits_left  <= 5'd0;
      k          <= 4'd0;
      nib_buf    <= 32'd0;
      run_bit    <= 1'b0;
      run_len    <= 3'd0;
      from_flush <= 1'b0;
      ended      <= 1'b0;
      load_q     <= 1'b0;
      data       <= 32'd0;
    end else begin
      load_q <= !ended && (state != S_END) && (state_next != S_END);
      case (state)
        S_IDLE: begin
          if (!flush && field_valid) begin
            field_sr  <= field_data << (FIELD_W - int'(eff_len));
            bits_left <= eff_len;
          end
        end
        S_SHIFT: begin
          field_sr  <= field_sr << 1;
          bits_left <= bits_left - 5'd1;
          if (run_len == 3'd0) begin
            run_bit <= cur_bit;
            run_len <= 3'd1;
          end else if (close_run) begin
            nib_buf <= buf_ins;
            k       <= k + 4'd1;
            run_bit <= cur_bit;
            run_len <= 3'd1;
            if (word_full) data <= buf_ins;
          end else begin
            run_len <= run_len + 3'd1;
          end
        end
        S_FLUSH: begin
          from_flush <= 1'b1;
          run_len    <= 3'd0;
          if (run_len != 3'd0) begin
            nib_buf <= buf_ins;
            k       <= k + 4'd1;
            data    <= buf_ins;
          end else if (k != 4'd0) begin
            data    <= nib_buf;
          end
        end
        S_EMIT: begin
          if (done_cpu) begin
            k          <= 4'd0;
            nib_buf    <= 32'd0;
            from_flush <= 1'b0;
          end
        end
        S_END:   ended <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RLE_WORD_COUNT_EN
  logic [15:0] word_cnt_q;

  // Count words the decoder has consumed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              word_cnt_q <= 16'd0;
    else if (state == S_EMIT && done_cpu)  word_cnt_q <= word_cnt_q + 16'd1;
  end

  assign word_count = word_cnt_q;
`else
  assign word_count = 16'd0;
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// tb/tb_rle_encoder.sv - scoreboard bench for rle_encoder with a stream-level reference model
module tb_rle_encoder;

  logic        clk;
  logic        rst;
  logic        field_valid;
  logic [15:0] field_data;
  logic [4:0]  field_len;
  logic        field_ready;
  logic        flush;
  logic [31:0] data;
  logic        interrupt;
  logic        load_process;
  logic        done_cpu;
  logic [15:0] word_count;

  rle_encoder #(.FIELD_W(16)) dut (
    .clk(clk), .rst(rst), .field_valid(field_valid), .field_data(field_data),
    .field_len(field_len), .field_ready(field_ready), .flush(flush), .data(data),
    .interrupt(interrupt), .load_process(load_process), .done_cpu(done_cpu),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] sb[$];           // {is_end_strobe, word}
  logic        stream[$];       // every field bit accepted this session, in order
  logic [3:0]  nib_q[$];
  int          words_pushed = 0;

  logic        hold_done = 1'b0;
  logic        spurious  = 1'b0;
  int          consumed  = 0;
  int          ends_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference model: RLE of the whole stream, runs capped at 7, chunked into 8-nibble words
  function automatic void build_nibs();
    int i = 0;
    nib_q.delete();
    while (i < stream.size()) begin
      logic b = stream[i];
      int   l = 0;
      while (i < stream.size() && stream[i] == b && l < 7) begin
        l++;
        i++;
      end
      nib_q.push_back({b, 3'(l)});
    end
  endfunction

  function automatic void push_word();
    logic [31:0] w = 32'd0;
    for (int j = 0; j < 8; j++) begin
      int idx = words_pushed * 8 + j;
      if (idx < nib_q.size()) w[31-4*j -: 4] = nib_q[idx];
    end
    sb.push_back({1'b0, w});
    words_pushed++;
  endfunction

  function automatic void model_field(input logic [15:0] d, input int len);
    int l = (len > 16) ? 16 : len;
    for (int i = l - 1; i >= 0; i--) stream.push_back(d[i]);
    build_nibs();
    // the last run is still open, so only the others can complete a word
    while ((words_pushed + 1) * 8 <= nib_q.size() - 1) push_word();
  endfunction

  function automatic void model_flush();
    build_nibs();
    while (words_pushed * 8 < nib_q.size()) push_word();
    sb.push_back({1'b1, 32'd0});
  endfunction

  function automatic void model_clear();
    stream.delete();
    nib_q.delete();
    words_pushed = 0;
    sb.delete();
  endfunction

  // Decoder model: consumes each presented word after a random delay
  initial begin
    int dly = 0;
    done_cpu = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (done_cpu) done_cpu = 1'b0;
      else if (rst && interrupt && load_process && !hold_done) begin
        if (dly == 0) begin
          done_cpu = 1'b1;
          dly = $urandom_range(0, 3);
        end else dly--;
      end else if (rst && spurious && !interrupt && $urandom_range(0, 7) == 0) begin
        done_cpu = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a word or the END strobe is presented
  initial begin
    logic        in_word = 1'b0;
    logic        after_consume = 1'b0;
    logic        prev_end = 1'b0;
    logic [31:0] held = 32'd0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_word = 1'b0;
        after_consume = 1'b0;
        prev_end = 1'b0;
        consumed = 0;
      end else begin
        if (after_consume && load_process) check("int_gap", interrupt, 0);
        after_consume = 1'b0;
        if (prev_end) begin
          check("end_one_cycle", {interrupt, load_process}, 2'b00);
          prev_end = 1'b0;
        end else if (interrupt && load_process) begin
          if (!in_word) begin
            in_word = 1'b1;
            held = data;
            if (sb.size() == 0) check("unexpected_word", data, 0);
            else begin
              e = sb.pop_front();
              check("word", {1'b0, data}, e);
            end
          end else check("word_hold", data, held);
          if (done_cpu) begin
            in_word = 1'b0;
            after_consume = 1'b1;
            consumed++;
          end
        end else if (interrupt) begin
          if (sb.size() == 0) check("unexpected_end", 1, 0);
          else begin
            e = sb.pop_front();
            check("end_strobe", e[32], 1);
          end
          ends_seen++;
          prev_end = 1'b1;
        end
      end
    end
  end

  task automatic wait_ready();
    int g = 0;
    @(negedge clk);
    while (!field_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (!field_ready) fail("ready_timeout");
  endtask

  task automatic drive_field(input logic [15:0] d, input logic [4:0] len);
    wait_ready();
    field_valid = 1'b1;
    field_data  = d;
    field_len   = len;
    @(negedge clk);
    field_valid = 1'b0;
    field_data  = 16'd0;
    field_len   = 5'd0;
  endtask

  task automatic drive_flush();
    wait_ready();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_interrupt();
    int g = 0;
    while (!interrupt && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!interrupt) fail("interrupt_timeout");
  endtask

  task automatic end_session();
    int g = 0;
    int start = ends_seen;
    int exp_wc;
    while (ends_seen == start && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (ends_seen == start) fail("end_timeout");
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("load_stays_low", load_process, 0);
`ifdef RLE_WORD_COUNT_EN
    exp_wc = consumed;
`else
    exp_wc = 0;
`endif
    check("word_count", word_count, 16'(exp_wc));
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("load_after_reset", load_process, 1);
    check("ready_after_reset", field_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    hold_done = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    release_reset();
  endtask

  task automatic directed_small();
    sb.push_back({1'b0, 32'h39190000});
    sb.push_back({1'b1, 32'd0});
    drive_field(16'h0005, 5'd6);
    drive_flush();
    end_session();
  endtask

  initial begin
    rst = 1'b0;
    field_valid = 1'b0;
    field_data = 16'd0;
    field_len = 5'd0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_interrupt", interrupt, 0);
    check("rst_word_count", word_count, 0);
    check("rst_ready", field_ready, 1);
    release_reset();

    // 6-bit field then flush
    directed_small();

    // all-ones field: runs of 7, 7, 2
    do_reset();
    sb.push_back({1'b0, 32'hFFA00000});
    sb.push_back({1'b1, 32'd0});
    drive_field(16'hFFFF, 5'd16);
    drive_flush();
    end_session();

    // alternating bits fill a word mid-field; decoder stalls, then shifting resumes
    do_reset();
    hold_done = 1'b1;
    sb.push_back({1'b0, 32'h91919191});
    drive_field(16'hAAAA, 5'd16);
    wait_interrupt();
    repeat (10) begin
      @(negedge clk);
      check("stall_interrupt", interrupt, 1);
      check("stall_ready", field_ready, 0);
    end
    sb.push_back({1'b0, 32'h91919191});
    sb.push_back({1'b1, 32'd0});
    hold_done = 1'b0;
    drive_flush();
    end_session();

    // flush with nothing open goes straight to END
    do_reset();
    sb.push_back({1'b1, 32'd0});
    drive_flush();
    end_session();

    // reset during a stalled EMIT clears the output word at once
    do_reset();
    hold_done = 1'b1;
    sb.push_back({1'b0, 32'h91919191});
    drive_field(16'hAAAA, 5'd16);
    wait_interrupt();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_emit_interrupt", interrupt, 0);
    check("async_emit_data", data, 0);
    check("async_emit_ready", field_ready, 1);
    hold_done = 1'b0;
    model_clear();
    release_reset();
    directed_small();

    // reset while the 9th bit of a 16-bit field is shifting
    do_reset();
    drive_field(16'hAAAA, 5'd16);
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_shift_interrupt", interrupt, 0);
    check("async_shift_data", data, 0);
    check("async_shift_ready", field_ready, 1);
    check("async_shift_word_count", word_count, 0);
    model_clear();
    release_reset();
    directed_small();

    // randomized sessions, including zero and over-long field lengths
    spurious = 1'b1;
    for (int s = 0; s < 8; s++) begin
      int nf = $urandom_range(1, 10);
      do_reset();
      for (int f = 0; f < nf; f++) begin
        logic [15:0] d = 16'($urandom);
        int          l = $urandom_range(0, 20);
        drive_field(d, 5'(l));
        model_field(d, l);
      end
      drive_flush();
      model_flush();
      end_session();
    end
    spurious = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
